// File: rtl/quad_mem_arbiter.sv
// Data-memory arbiter shared by the CPU memory stage and a quadrant pixel fetch engine.
// CPU wins by default; a starvation counter forces a fetch grant after MAX_WAIT denials.
module quad_mem_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int IMG_W    = 400,
    parameter int QUAD_W   = 100,
    parameter int QUAD_H   = 100,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cuadrante,
    input  logic              start,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] cpu_wdata,
    input  logic              cpu_byte,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic              mem_byte,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done
);
    localparam int XW = $clog2(QUAD_W);
    localparam int YW = $clog2(QUAD_H);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q;
    logic [SW-1:0]     starve_q;
    logic [7:0]        buf_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              fetch_inflight_q, cpu_rd_q, done_q;

    logic              pop, fetch_want, force_fetch, fetch_grant, cpu_grant;
    logic              last_fetch, last_accept;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] fetch_addr, base;

    assign pix_valid  = (count_q != 2'd0);
    assign pix_data   = pix_valid ? buf_q[rd_ptr_q] : '0;
    assign pop        = pix_valid & pix_ready;
    // Occupancy counts in-flight reads and credits a pop happening this cycle.
    assign pending    = {1'b0, count_q} + {2'b0, fetch_inflight_q} - {2'b0, pop};
    assign fetch_want = (state_q == SCAN) && (pending < 3'd2);

    assign force_fetch = fetch_want && (starve_q == SW'(MAX_WAIT));
    assign fetch_grant = !reset && fetch_want && (!cpu_req || force_fetch);
    assign cpu_grant   = !reset && cpu_req && !force_fetch;
    assign cpu_stall   = !reset && cpu_req && !cpu_grant;
    assign cpu_rvalid  = cpu_rd_q;
    assign cpu_rdata   = cpu_rd_q ? mem_rdata : '0;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

    assign fetch_addr  = row_base_q + ADDR_W'(x_q);
    assign base        = ADDR_W'(cuadrante[3:2]) * ADDR_W'(QUAD_H * IMG_W)
                       + ADDR_W'(cuadrante[1:0]) * ADDR_W'(QUAD_W);
    assign last_fetch  = fetch_grant && (x_q == XW'(QUAD_W - 1)) && (y_q == YW'(QUAD_H - 1));
    assign last_accept = (state_q == DRAIN) && pop && (count_q == 2'd1) && !fetch_inflight_q;

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        x_d        = x_q;
        y_d        = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    row_base_d = base;
                    x_d        = '0;
                    y_d        = '0;
                end
            end
            SCAN: begin
                if (fetch_grant) begin
                    if (x_q == XW'(QUAD_W - 1)) begin
                        x_d        = '0;
                        y_d        = y_q + 1'b1;
                        row_base_d = row_base_q + ADDR_W'(IMG_W);
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (last_fetch) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With no grant the address bus holds its last value and nothing is written.
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_byte  = 1'b0;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_we ? cpu_wdata : '0;
            mem_byte  = cpu_byte;
        end else if (fetch_grant) begin
            mem_addr = fetch_addr;
            mem_byte = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            row_base_q       <= '0;
            x_q              <= '0;
            y_q              <= '0;
            addr_q           <= '0;
            starve_q         <= '0;
            buf_q[0]         <= '0;
            buf_q[1]         <= '0;
            wr_ptr_q         <= 1'b0;
            rd_ptr_q         <= 1'b0;
            count_q          <= '0;
            fetch_inflight_q <= 1'b0;
            cpu_rd_q         <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            row_base_q       <= row_base_d;
            x_q              <= x_d;
            y_q              <= y_d;
            addr_q           <= mem_addr;
            fetch_inflight_q <= fetch_grant;
            cpu_rd_q         <= cpu_grant & ~cpu_we;
            done_q           <= last_accept;
            if (fetch_want && !fetch_grant) starve_q <= starve_q + 1'b1;
            else                            starve_q <= '0;
            if (fetch_inflight_q) begin
                buf_q[wr_ptr_q] <= mem_rdata[7:0];
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, fetch_inflight_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_quad_mem_arbiter.sv
// Directed self-checking bench for quad_mem_arbiter with a synchronous-read RAM model.
// Inputs change 1 ns after posedge; outputs are checked on the falling edge.
module tb_quad_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset, start, cpu_req, cpu_we, cpu_byte, pix_ready;
    logic [3:0]  cuadrante;
    logic [18:0] cpu_addr, cpu_wdata, mem_rdata;
    logic        cpu_stall, cpu_rvalid, mem_we, mem_byte, pix_valid, busy, done;
    logic [18:0] cpu_rdata, mem_addr, mem_wdata;
    logic [7:0]  pix_data;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] ram [0:524287];
    logic [7:0]  got [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_acc_cyc = -1;
    int          fetch_cnt = 0;
    logic [18:0] last_fetch = '0;
    int          q5_base = 0;

    always #5 clk = ~clk;

    quad_mem_arbiter #(
        .ADDR_W(19), .IMG_W(400), .QUAD_W(100), .QUAD_H(100), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .reset(reset), .cuadrante(cuadrante), .start(start),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byte(cpu_byte), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_byte(mem_byte), .mem_rdata(mem_rdata), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    function automatic logic [7:0] pix_of(input int a);
        return 8'((a * 37) ^ (a >>> 8) ^ 32'h5A);
    endfunction

    function automatic int exp_addr(input logic [3:0] q, input int k);
        return int'(q[3:2]) * 40000 + int'(q[1:0]) * 100 + (k / 100) * 400 + (k % 100);
    endfunction

    initial begin
        for (int a = 0; a < 524288; a++) ram[a] = {3'b101, 8'(a >> 3), pix_of(a)};
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (pix_valid && pix_ready) begin
                got.push_back(pix_data);
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && mem_byte && !mem_we && !cpu_req) begin
                fetch_cnt++;
                last_fetch = mem_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1;
        cpu_addr = 19'h123; cpu_wdata = 19'h7FFFF; cuadrante = 4'h5; pix_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({cpu_stall, cpu_rvalid, cpu_rdata, mem_addr, mem_we, mem_wdata, mem_byte,
             pix_valid, pix_data, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h wdata=%h we=%b byte=%b pv=%b busy=%b exp all 0",
                     mem_addr, mem_wdata, mem_we, mem_byte, pix_valid, busy);
        end
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall);
        end
        step();
        start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle busy=%b pix_valid=%b exp 0 0", busy, pix_valid);
        end
    endtask

    task automatic test_scan_q5();
        step();
        cuadrante = 4'h5; start = 1'b1; pix_ready = 1'b1;
        q5_base = got.size();
        step();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 19'd40100 || mem_byte !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch addr=%0d byte=%b we=%b busy=%b exp 40100 1 0 1",
                     mem_addr, mem_byte, mem_we, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_addr !== 19'd40101) begin
            errors++; $display("FAIL second_fetch got=%0d exp=40101", mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== pix_of(40100)) begin
            errors++; $display("FAIL first_pixel valid=%b data=%h exp 1 %h", pix_valid, pix_data, pix_of(40100));
        end
        repeat (98) step();
        @(negedge clk);
        checks++;
        if (mem_addr !== 19'd40500) begin
            errors++; $display("FAIL pixel101_addr got=%0d exp=40500", mem_addr);
        end
    endtask

    task automatic test_cpu_access();
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1; cpu_addr = 19'h6; cpu_wdata = 19'h0EEFF;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 19'h6 ||
            mem_wdata !== 19'h0EEFF || mem_byte !== 1'b1) begin
            errors++;
            $display("FAIL cpu_write stall=%b we=%b addr=%h wdata=%h byte=%b exp 0 1 6 0eeff 1",
                     cpu_stall, mem_we, mem_addr, mem_wdata, mem_byte);
        end
        step();
        cpu_we = 1'b0; cpu_byte = 1'b0; cpu_wdata = '0;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 19'h6 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read stall=%b we=%b addr=%h rvalid=%b exp 0 0 6 0",
                     cpu_stall, mem_we, mem_addr, cpu_rvalid);
        end
        step();
        cpu_req = 1'b0; cpu_addr = '0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 19'h0EEFF) begin
            errors++; $display("FAIL cpu_rdata rvalid=%b data=%h exp 1 0eeff", cpu_rvalid, cpu_rdata);
        end
        checks++;
        if (mem_addr !== 19'd40501 || mem_byte !== 1'b1) begin
            errors++; $display("FAIL scan_resume addr=%0d byte=%b exp 40501 1", mem_addr, mem_byte);
        end
    endtask

    task automatic test_starvation();
        logic        exp_f;
        logic [18:0] exp_a;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 19'h10;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) step();
            @(negedge clk);
            exp_f = (i == 5) || (i == 10);
            exp_a = (i == 5) ? 19'd40502 : (i == 10) ? 19'd40503 : 19'h10;
            checks++;
            if (cpu_stall !== exp_f) begin
                errors++; $display("FAIL starve_stall cycle %0d got=%b exp=%b", i, cpu_stall, exp_f);
            end
            checks++;
            if (mem_addr !== exp_a) begin
                errors++; $display("FAIL starve_addr cycle %0d got=%0d exp=%0d", i, mem_addr, exp_a);
            end
        end
    endtask

    task automatic test_backpressure();
        int g0;
        int grants = 0;
        step();
        cpu_req = 1'b0; cpu_addr = '0; pix_ready = 1'b0;
        g0 = got.size();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (mem_byte && !mem_we) grants++;
        end
        checks++;
        if (grants != 1) begin
            errors++; $display("FAIL stall_grants got=%0d exp=1", grants);
        end
        checks++;
        if (got.size() != g0 || pix_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold accepted=%0d valid=%b exp 0 1", got.size() - g0, pix_valid);
        end
        step();
        pix_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_data !== pix_of(40503)) begin
            errors++; $display("FAIL release_pix0 got=%h exp=%h", pix_data, pix_of(40503));
        end
        step();
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== pix_of(40504)) begin
            errors++; $display("FAIL release_pix1 valid=%b got=%h exp=%h", pix_valid, pix_data, pix_of(40504));
        end
    endtask

    task automatic test_scan_finish();
        int d0 = done_cnt;
        int bad = 0;
        for (int c = 0; c < 12000 && done_cnt == d0; c++) step();
        repeat (5) step();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL q5_done_count got=%0d exp=1", done_cnt - d0);
        end
        checks++;
        if (done_cyc != last_acc_cyc + 1) begin
            errors++; $display("FAIL q5_done_timing done_cyc=%0d exp=%0d", done_cyc, last_acc_cyc + 1);
        end
        checks++;
        if (got.size() - q5_base != 10000) begin
            errors++; $display("FAIL q5_pixel_count got=%0d exp=10000", got.size() - q5_base);
        end
        if (got.size() - q5_base >= 10000) begin
            for (int k = 0; k < 10000; k++)
                if (got[q5_base + k] !== pix_of(exp_addr(4'h5, k))) bad++;
        end else begin
            bad = 10000;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL q5_pixel_order mismatches=%0d exp=0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL q5_idle busy=%b exp=0", busy);
        end
    endtask

    task automatic test_full_scan_f();
        int g0, f0, d0;
        int bad = 0;
        step();
        cuadrante = 4'hF; start = 1'b1; pix_ready = 1'b1;
        step();
        start = 1'b0;
        g0 = got.size(); f0 = fetch_cnt; d0 = done_cnt;
        for (int c = 0; c < 20000 && done_cnt == d0; c++) begin
            step();
            pix_ready = (c % 4) != 3;
            start     = (c == 500);
            cuadrante = (c == 500) ? 4'h0 : 4'hF;
            if (c == 502) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL start_ignored busy=%b exp=1", busy);
                end
            end
        end
        pix_ready = 1'b1; start = 1'b0;
        repeat (3) step();
        checks++;
        if (last_fetch !== 19'd159999) begin
            errors++; $display("FAIL qF_last_addr got=%0d exp=159999", last_fetch);
        end
        checks++;
        if (fetch_cnt - f0 != 10000) begin
            errors++; $display("FAIL qF_fetch_count got=%0d exp=10000", fetch_cnt - f0);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != last_acc_cyc + 1) begin
            errors++;
            $display("FAIL qF_done count=%0d cyc=%0d exp 1 %0d", done_cnt - d0, done_cyc, last_acc_cyc + 1);
        end
        if (got.size() - g0 == 10000) begin
            for (int k = 0; k < 10000; k++)
                if (got[g0 + k] !== pix_of(exp_addr(4'hF, k))) bad++;
        end else begin
            bad = 10000;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL qF_pixel_order mismatches=%0d count=%0d exp 0 10000", bad, got.size() - g0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int d0;
        step();
        cuadrante = 4'hF; start = 1'b1; pix_ready = 1'b1;
        step();
        start = 1'b0;
        d0 = done_cnt;
        repeat (300) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || mem_byte !== 1'b0 || mem_addr !== 19'd0) begin
            errors++;
            $display("FAIL midscan_reset busy=%b pv=%b byte=%b addr=%0d exp 0 0 0 0",
                     busy, pix_valid, mem_byte, mem_addr);
        end
        step();
        reset = 1'b0;
        repeat (30) step();
        @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL midscan_no_done done=%0d busy=%b pv=%b exp 0 0 0", done_cnt - d0, busy, pix_valid);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cuadrante = '0; pix_ready = 1'b0;
        test_reset();
        test_scan_q5();
        test_cpu_access();
        test_starvation();
        test_backpressure();
        test_scan_finish();
        test_full_scan_f();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_mem_arbiter.md
Name: quad_mem_arbiter

Overview:
- Shares the single-port data memory between the pipeline memory stage (load/store) and a quadrant display fetch engine.
- The fetch engine streams the 8-bit pixels of one 100x100 quadrant of a 400x400 image to the display path over a valid/ready interface.
- The CPU has priority, with a starvation guard for the fetch engine. The block sits between the memory stage and the data RAM.

Parameters:
ADDR_W, 19, address and data width
IMG_W, 400, image width in pixels (4*QUAD_W)
QUAD_W, 100, quadrant width
QUAD_H, 100, quadrant height
MAX_WAIT, 4, consecutive denied fetch cycles before the fetch engine is forced a grant

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cuadrante  in  4  quadrant index: row = [3:2], column = [1:0]; sampled at start
start  in  1  one-cycle pulse that begins a quadrant scan
cpu_req  in  1  memory stage requests an access
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  19  CPU address
cpu_wdata  in  19  CPU write data
cpu_byte  in  1  1 = byte access, 0 = 2-byte access (Cant_Byte)
cpu_stall  out  1  CPU request not granted this cycle
cpu_rvalid  out  1  cpu_rdata valid (cycle after a granted CPU read)
cpu_rdata  out  19  mem_rdata passthrough
mem_addr  out  19  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  19  RAM write data
mem_byte  out  1  RAM access size
mem_rdata  in  19  RAM read data, valid 1 cycle after address
pix_valid  out  1  pixel available
pix_data  out  8  pixel value
pix_ready  in  1  downstream accepts the pixel
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end

Behaviour:
- Reset: all outputs 0; FSM to IDLE; pixel buffer and in-flight tag cleared; starvation counter 0.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE to SCAN on start. On that transition, latch cuadrante and set base = cuadrante[3:2]*QUAD_H*IMG_W + cuadrante[1:0]*QUAD_W. Set x = 0, row_base = base.
  - In SCAN, fetch address = row_base + x. After each granted fetch, x++. When x reaches QUAD_W-1 and is granted: x = 0, row_base += IMG_W.
  - SCAN to DRAIN when the fetch of pixel QUAD_W*QUAD_H is granted.
  - DRAIN to IDLE when the last pixel is accepted (pix_valid & pix_ready). done = 1 in the following cycle.
  - busy = 1 in SCAN and DRAIN. start is ignored unless in IDLE. cuadrante changes during a scan are ignored.
- Fetch request (fetch_want): asserted in SCAN when buffer occupancy + in-flight reads < 2, counting a pop in the same cycle.
  - The buffer is a 2-entry FIFO of mem_rdata[7:0], written the cycle after a granted fetch.
  - Fetches use mem_we = 0 and mem_byte = 1.
- Arbitration is combinational on the current cycle.
  - Default: cpu_req wins.
  - If the starvation counter equals MAX_WAIT and fetch_want = 1, the fetch wins and cpu_stall = 1 for that cycle.
  - The starvation counter increments each cycle fetch_want = 1 and the fetch is denied. It clears on a fetch grant or when fetch_want = 0.
  - cpu_stall = cpu_req & ~cpu_grant.
  - When nothing is granted: mem_we = 0 and mem_addr holds its previous value.
- Read return:
  - A 1-bit owner tag is registered at grant and routes mem_rdata the next cycle.
  - cpu_rvalid = 1 only for a granted CPU read (cpu_we = 0).
  - CPU writes drive mem_we/mem_wdata/mem_byte directly in the grant cycle.
- Pixels leave in address order; none are dropped or duplicated under any pix_ready pattern.
- Reset mid-scan: return to IDLE immediately, flush the buffer, drop the in-flight read, done not asserted.
- Address arithmetic is unsigned 19-bit. The maximum address, 159999, fits, so there is no wrap.

Test Plan:
1. Reset asserted with cpu_req = 1 and start = 1 -> all outputs 0 in the cycle after, cpu_stall = 0, busy = 0.
2. cuadrante = 4'h5, start, no CPU traffic, pix_ready = 1:
   - first mem_addr = 0x09CA4 (40100), then 0x09CA5.
   - pixel 101 address = 0x09E34 (40500).
   - pix_data matches preloaded RAM bytes.
3. During a scan, CPU write 19'h0EEFF to 0x6 with cpu_byte = 1, then a CPU read of 0x6 -> both granted without stall; cpu_rvalid with cpu_rdata = RAM[0x6] one cycle after the read; the scan resumes at the next address.
4. cpu_req held high for 10 cycles during SCAN, MAX_WAIT = 4 -> fetch denied 4 cycles, granted on cycle 5 (cpu_stall = 1 only then), denied 4 more, granted on cycle 10.
5. pix_ready = 0 for 20 cycles -> exactly 2 pixels buffered, no further fetch grants; on pix_ready = 1 the pixels emerge in order with no loss.
6. cuadrante = 4'hF, full scan:
   - last mem_addr = 0x270FF (159999); done pulses once after the 10000th accept.
   - start mid-scan is ignored.
   - A repeat run with reset mid-scan -> IDLE next cycle, pix_valid = 0, no done.
